tc_program_loader: RTL and testbench

//  Writer side of the TC program memory: receives a framed byte stream (valid/ready) from the host or debug

---
 rtl/tc_program_loader.sv | 168 ++++++++++++++++
 tb/tb_tc_program_loader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_program_loader.sv
// tc_program_loader: writer side of the TC program memory.
// Parses a framed byte stream ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, LEN data bytes [, CKSUM].
// Each data byte produces a registered byte-write strobe into the program memory.
// The optional trailing checksum byte is enabled by defining TC_LOADER_CKSUM_EN.
// When it is enabled, err is a sticky flag that is cleared at the next frame start.
// When it is not defined, frames end after the last data byte and err is tied low.
module tc_program_loader #(
    parameter int unsigned MEM_BYTES  = 65536,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  mem_hold,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]            wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        StIdle,
        StAddrHi,
        StLenLo,
        StLenHi,
        StData,
        StCksum,
        StDone
    } state_t;

    // The frame address is kept at full 16 bits.
    // Masking it to MEM_BYTES gives modulo wrap for any power-of-two size.
    localparam logic [15:0] ADDR_MASK = 16'(MEM_BYTES - 1);

`ifdef TC_LOADER_CKSUM_EN
    localparam state_t POST_PAYLOAD = StCksum;
`else
    localparam state_t POST_PAYLOAD = StDone;
`endif

    state_t      state;
    logic [15:0] cur_addr;
    logic [15:0] remaining;
    logic        xfer;

`ifdef TC_LOADER_CKSUM_EN
    logic [7:0]  sum;
    logic        err_q;
`endif

    // The loader can accept a byte in every state except the single DONE cycle.
    always_comb begin
        in_ready = !mem_hold && (state != StDone);
        xfer     = in_valid && in_ready;
        busy     = (state != StIdle);
    end

    // Frame parser FSM with registered write strobe and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            cur_addr  <= 16'h0000;
            remaining <= 16'h0000;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= 8'h00;
            done      <= 1'b0;
`ifdef TC_LOADER_CKSUM_EN
            sum       <= 8'h00;
            err_q     <= 1'b0;
`endif
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (xfer) begin
                        cur_addr[7:0] <= in_data;
                        state         <= StAddrHi;
`ifdef TC_LOADER_CKSUM_EN
                        sum           <= in_data;
                        err_q         <= 1'b0;
`endif
                    end
                end
                StAddrHi: begin
                    if (xfer) begin
                        cur_addr[15:8] <= in_data;
                        state          <= StLenLo;
`ifdef TC_LOADER_CKSUM_EN
                        sum            <= 8'(sum + in_data);
`endif
                    end
                end
                StLenLo: begin
                    if (xfer) begin
                        remaining[7:0] <= in_data;
                        state          <= StLenHi;
`ifdef TC_LOADER_CKSUM_EN
                        sum            <= 8'(sum + in_data);
`endif
                    end
                end
                StLenHi: begin
                    if (xfer) begin
                        remaining[15:8] <= in_data;
`ifdef TC_LOADER_CKSUM_EN
                        sum             <= 8'(sum + in_data);
`endif
                        if ({in_data, remaining[7:0]} != 16'h0000) begin
                            state <= StData;
                        end else begin
                            state <= POST_PAYLOAD;
                            done  <= (POST_PAYLOAD == StDone);
                        end
                    end
                end
                StData: begin
                    if (xfer) begin
                        wr_en     <= 1'b1;
                        wr_addr   <= ADDR_WIDTH'(cur_addr & ADDR_MASK);
                        wr_data   <= in_data;
                        cur_addr  <= cur_addr + 16'h0001;
                        remaining <= remaining - 16'h0001;
`ifdef TC_LOADER_CKSUM_EN
                        sum       <= 8'(sum + in_data);
`endif
                        if (remaining == 16'h0001) begin
                            state <= POST_PAYLOAD;
                            done  <= (POST_PAYLOAD == StDone);
                        end
                    end
                end
                StCksum: begin
`ifdef TC_LOADER_CKSUM_EN
                    if (xfer) begin
                        if (8'(sum + in_data) != 8'h00) begin
                            err_q <= 1'b1;
                        end
                        sum   <= 8'(sum + in_data);
                        state <= StDone;
                        done  <= 1'b1;
                    end
`else
                    state <= StIdle;
`endif
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

`ifdef TC_LOADER_CKSUM_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_tc_program_loader.sv
// Self-checking bench for tc_program_loader.
// A frame-level model predicts the outputs from the byte index within the frame.
// Every cycle is compared against that model.
// Directed tests then pin the write log against hand-computed literals.
module tb_tc_program_loader;

    localparam int MEM = 65536;
`ifdef TC_LOADER_CKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_hold = 1'b0;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;
    logic        err;

    tc_program_loader #(.MEM_BYTES(65536), .ADDR_WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .mem_hold(mem_hold),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;
    wr_t wr_log[$];
    int  done_cnt = 0;

    bit          m_init = 0;
    int          m_idx = 0;
    logic [7:0]  m_hdr[4];
    int          m_sum = 0;
    bit          m_done_phase = 0;
    bit          m_ready;
    bit          exp_wr_en = 0, exp_done = 0, exp_err = 0, exp_busy = 0;
    int          exp_addr = 0;
    logic [7:0]  exp_data = 8'h00;
    logic        s_rst, s_v, s_h;
    logic [7:0]  s_d;
    bit          hold_rand = 0;

    function automatic int frame_len();
        return int'({m_hdr[3], m_hdr[2]});
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            #4;
            s_rst = rst; s_v = in_valid; s_d = in_data; s_h = mem_hold;
            m_ready = !s_h && !m_done_phase;
            if (m_init && !s_rst) chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
            @(posedge clk);
            #1;
            if (s_rst) begin
                m_init = 1; m_idx = 0; m_done_phase = 0; m_sum = 0;
                exp_wr_en = 0; exp_done = 0; exp_err = 0;
            end else if (m_init) begin
                exp_wr_en = 0;
                exp_done = 0;
                if (m_done_phase) begin
                    m_done_phase = 0;
                end else if (s_v && m_ready) begin
                    if (m_idx == 0) begin
                        m_sum = 0;
                        exp_err = 0;
                    end
                    m_sum = (m_sum + int'(s_d)) % 256;
                    if (m_idx < 4) begin
                        m_hdr[m_idx] = s_d;
                    end else if (m_idx < 4 + frame_len()) begin
                        exp_wr_en = 1;
                        exp_addr = (int'({m_hdr[1], m_hdr[0]}) + m_idx - 4) % MEM;
                        exp_data = s_d;
                    end else begin
                        exp_err = (m_sum != 0);
                    end
                    m_idx++;
                    if (m_idx >= 4 && m_idx == 4 + frame_len() + CK) begin
                        m_idx = 0;
                        m_done_phase = 1;
                        exp_done = 1;
                    end
                end
            end
            exp_busy = (m_idx != 0) || m_done_phase;
            if (m_init) begin
                chk("wr_en", {31'd0, wr_en}, {31'd0, exp_wr_en});
                chk("done", {31'd0, done}, {31'd0, exp_done});
                chk("busy", {31'd0, busy}, {31'd0, exp_busy});
                chk("err", {31'd0, err}, {31'd0, exp_err});
                if (exp_wr_en) begin
                    chk("wr_addr", {16'd0, wr_addr}, 32'(exp_addr));
                    chk("wr_data", {24'd0, wr_data}, {24'd0, exp_data});
                end
            end
            if (wr_en === 1'b1) wr_log.push_back('{a: wr_addr, d: wr_data});
            if (done === 1'b1) done_cnt++;
        end
    end

    // Random back-pressure from the memory while enabled.
    always @(negedge clk) mem_hold = hold_rand ? 1'($urandom_range(0, 1)) : 1'b0;

    // ---------------- stimulus helpers ----------------
    logic [7:0] frame_q[$];

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        forever begin
            #4;
            if (in_ready === 1'b1) begin
                @(negedge clk);
                in_valid = 1'b0;
                break;
            end
            n++;
            if (n > 500) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got no in_ready expected ready within 500 cycles");
                @(negedge clk);
                in_valid = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_begin(input logic [15:0] a, input logic [15:0] n);
        frame_q.delete();
        frame_q.push_back(a[7:0]);
        frame_q.push_back(a[15:8]);
        frame_q.push_back(n[7:0]);
        frame_q.push_back(n[15:8]);
    endtask

    task automatic frame_send(input bit gaps);
`ifdef TC_LOADER_CKSUM_EN
        logic [7:0] s = 8'h00;
        foreach (frame_q[i]) s = s + frame_q[i];
        frame_q.push_back(8'(8'h00 - s));
`endif
        foreach (frame_q[i]) begin
            if (gaps) idle($urandom_range(0, 2));
            send(frame_q[i]);
        end
    endtask

    task automatic chk_wr(input int idx, input logic [15:0] a, input logic [7:0] d);
        if (idx < wr_log.size()) begin
            chk($sformatf("log%0d_addr", idx), {16'd0, wr_log[idx].a}, {16'd0, a});
            chk($sformatf("log%0d_data", idx), {24'd0, wr_log[idx].d}, {24'd0, d});
        end else begin
            chk($sformatf("log%0d_present", idx), 32'(wr_log.size()), 32'(idx + 1));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        idle(2);
        rst = 1'b0;
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_wr_addr", {16'd0, wr_addr}, 32'd0);
        chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);

        // Tests 1 and 2 back to back: the byte held through DONE must not be lost
        wr_log.delete(); done_cnt = 0;
        frame_begin(16'h0100, 16'd3);
        frame_q.push_back(8'hAA); frame_q.push_back(8'hBB); frame_q.push_back(8'hCC);
        frame_send(0);
        frame_begin(16'hFFFE, 16'd4);
        frame_q.push_back(8'h11); frame_q.push_back(8'h22);
        frame_q.push_back(8'h33); frame_q.push_back(8'h44);
        frame_send(0);
        idle(4);
        chk("t12_writes", 32'(wr_log.size()), 32'd7);
        chk_wr(0, 16'h0100, 8'hAA);
        chk_wr(1, 16'h0101, 8'hBB);
        chk_wr(2, 16'h0102, 8'hCC);
        chk_wr(3, 16'hFFFE, 8'h11);
        chk_wr(4, 16'hFFFF, 8'h22);
        chk_wr(5, 16'h0000, 8'h33);
        chk_wr(6, 16'h0001, 8'h44);
        chk("t12_done_cnt", 32'(done_cnt), 32'd2);
        chk("t12_busy", {31'd0, busy}, 32'd0);

        // Test 3: zero-length frame
        wr_log.delete(); done_cnt = 0;
        frame_begin(16'h0010, 16'd0);
        frame_send(0);
        idle(4);
        chk("t3_writes", 32'(wr_log.size()), 32'd0);
        chk("t3_done_cnt", 32'(done_cnt), 32'd1);

        // Test 4: gaps and mem_hold toggling during a 16-byte frame
        wr_log.delete(); done_cnt = 0;
        hold_rand = 1;
        frame_begin(16'h1234, 16'd16);
        for (int i = 0; i < 16; i++) frame_q.push_back(8'(i * 7 + 3));
        frame_send(1);
        hold_rand = 0;
        idle(4);
        chk("t4_writes", 32'(wr_log.size()), 32'd16);
        for (int i = 0; i < 16; i++) chk_wr(i, 16'(16'h1234 + i), 8'(i * 7 + 3));
        chk("t4_done_cnt", 32'(done_cnt), 32'd1);

        // Test 5: reset after 2 of 4 data bytes, then a fresh frame
        wr_log.delete(); done_cnt = 0;
        send(8'h40); send(8'h00); send(8'h04); send(8'h00);
        send(8'h01); send(8'h02);
        do_reset();
        idle(3);
        chk("t5_busy_after_rst", {31'd0, busy}, 32'd0);
        frame_begin(16'h0020, 16'd1);
        frame_q.push_back(8'h5A);
        frame_send(0);
        idle(4);
        chk("t5_writes", 32'(wr_log.size()), 32'd3);
        chk_wr(0, 16'h0040, 8'h01);
        chk_wr(1, 16'h0041, 8'h02);
        chk_wr(2, 16'h0020, 8'h5A);
        chk("t5_done_cnt", 32'(done_cnt), 32'd1);

`ifdef TC_LOADER_CKSUM_EN
        // Test 6: checksum good, bad, then cleared by the next frame
        wr_log.delete();
        send(8'h00); send(8'h00); send(8'h01); send(8'h00); send(8'h10); send(8'hEF);
        idle(2);
        chk("t6_err_good", {31'd0, err}, 32'd0);
        send(8'h00); send(8'h00); send(8'h01); send(8'h00); send(8'h10); send(8'hEE);
        idle(2);
        chk("t6_err_bad", {31'd0, err}, 32'd1);
        chk("t6_writes", 32'(wr_log.size()), 32'd2);
        chk_wr(1, 16'h0000, 8'h10);
        send(8'h30);
        chk("t6_err_cleared", {31'd0, err}, 32'd0);
        send(8'h00); send(8'h00); send(8'h00); send(8'hD0);
        idle(3);
        chk("t6_err_final", {31'd0, err}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
